// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory handshake states, machine word, and the
// write-through data cache entry layout.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    localparam int DCACHE_SETS  = 8;
    localparam int DCACHE_IDX_W = 3;
    localparam int DCACHE_TAG_W = 27;

    typedef struct packed {
        logic                    valid;
        logic [DCACHE_TAG_W-1:0] tag;
        word_t                   data;
    } dcache_entry_t;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FLUSHED} dcache_state_t;
endpackage

// File: rtl/dcache_if.sv
// Bundle of datapath-side and memory-side cache signals.
interface dcache_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic nRST
);
    logic      dREN, dWEN, halt;
    word_t     daddr, dstore;
    logic      dhit, flushed;
    word_t     dload, hitcount;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    modport cache (
        input  CLK, nRST, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
        output dhit, dload, flushed, hitcount, ramREN, ramWEN, ramaddr, ramstore
    );
    modport dp (
        input  CLK, nRST, dhit, dload, flushed, hitcount, ramREN, ramWEN, ramaddr, ramstore,
        output dREN, dWEN, daddr, dstore, halt, ramload, ramstate
    );
endinterface

// File: rtl/dcache_wt.sv
// 8-entry direct-mapped write-through, no-write-allocate data cache.
// Read hits complete combinationally; misses and all writes go to RAM.
module dcache_wt
    import cpu_types_pkg::*;
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  logic      halt,
    output logic      dhit,
    output word_t     dload,
    output logic      flushed,
    output word_t     hitcount,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);
    dcache_state_t r_state, w_next;
    dcache_entry_t r_entries [DCACHE_SETS];
    word_t         r_hitcount;

    logic [DCACHE_IDX_W-1:0] w_idx;
    logic [DCACHE_TAG_W-1:0] w_tag;
    dcache_entry_t           w_entry;
    logic                    w_match;
    logic                    w_cnt, w_fill, w_wr, w_flush;
    logic                    w_unused_bits;

    assign w_idx         = daddr[4:2];
    assign w_tag         = daddr[31:5];
    assign w_entry       = r_entries[w_idx];
    assign w_match       = w_entry.valid && (w_entry.tag == w_tag);
    assign w_unused_bits = &{1'b0, daddr[1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        dhit     = 1'b0;
        dload    = '0;
        flushed  = 1'b0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        w_cnt    = 1'b0;
        w_fill   = 1'b0;
        w_wr     = 1'b0;
        w_flush  = 1'b0;
        case (r_state)
            IDLE: begin
                if (dWEN) begin
                    w_next = WRITE;
                end else if (dREN) begin
                    if (w_match) begin
                        dhit  = 1'b1;
                        dload = w_entry.data;
                        w_cnt = 1'b1;
                    end else begin
                        w_next = FILL;
                    end
                end else if (halt) begin
                    w_next  = FLUSHED;
                    w_flush = 1'b1;
                end
            end
            FILL: begin
                ramREN  = 1'b1;
                ramaddr = {daddr[31:2], 2'b00};
                // A dropped request abandons the fill without touching the array.
                if (!dREN) begin
                    w_next = IDLE;
                end else if (ramstate == ACCESS) begin
                    dhit   = 1'b1;
                    dload  = ramload;
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
            WRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = {daddr[31:2], 2'b00};
                ramstore = dstore;
                if (!dWEN) begin
                    w_next = IDLE;
                end else if (ramstate == ACCESS) begin
                    dhit   = 1'b1;
                    w_wr   = 1'b1;
                    w_next = IDLE;
                end
            end
            FLUSHED: flushed = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DCACHE_SETS; i++) r_entries[i] <= '0;
        end else if (w_flush) begin
            for (int i = 0; i < DCACHE_SETS; i++) r_entries[i].valid <= 1'b0;
        end else if (w_fill) begin
            r_entries[w_idx] <= '{valid: 1'b1, tag: w_tag, data: ramload};
        end else if (w_wr && w_match) begin
            // Write-through keeps a resident copy coherent; misses do not allocate.
            r_entries[w_idx].data <= dstore;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      r_hitcount <= '0;
        else if (w_cnt) r_hitcount <= r_hitcount + 32'd1;
    end

    assign hitcount = r_hitcount;
endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: fills, hits, write-through, no-allocate,
// conflict eviction, write priority, error retry, flush and reset.
module tb_dcache_wt;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_hits = 0;

    always #5 CLK = ~CLK;

    dcache_if dif (.CLK(CLK), .nRST(nRST));

    dcache_wt dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dif.dREN), .dWEN(dif.dWEN), .daddr(dif.daddr), .dstore(dif.dstore),
        .halt(dif.halt), .dhit(dif.dhit), .dload(dif.dload), .flushed(dif.flushed),
        .hitcount(dif.hitcount), .ramREN(dif.ramREN), .ramWEN(dif.ramWEN),
        .ramaddr(dif.ramaddr), .ramstore(dif.ramstore), .ramload(dif.ramload),
        .ramstate(dif.ramstate)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        dif.dREN = 1'b0; dif.dWEN = 1'b0; dif.halt = 1'b0;
        dif.ramstate = FREE; dif.ramload = '0;
    endtask

    // Miss in IDLE, ACCESS on the first FILL cycle.
    task automatic fill(input word_t a, input word_t d);
        dif.dREN = 1'b1; dif.daddr = a; dif.ramstate = ACCESS; dif.ramload = d;
        #1;
        chk("fill_idle_dhit", 32'(dif.dhit), 32'd0);
        tick();
        chk("fill_dhit", 32'(dif.dhit), 32'd1);
        chk("fill_dload", dif.dload, d);
        chk("fill_ramaddr", dif.ramaddr, a);
        tick();
        quiet();
    endtask

    task automatic read_hit(input word_t a, input word_t d);
        dif.dREN = 1'b1; dif.daddr = a;
        #1;
        chk("hit_dhit", 32'(dif.dhit), 32'd1);
        chk("hit_dload", dif.dload, d);
        chk("hit_noramren", 32'(dif.ramREN), 32'd0);
        tick();
        exp_hits++;
        quiet();
        chk("hit_count", dif.hitcount, 32'(exp_hits));
    endtask

    // Confirms a miss, then drops the request mid-FILL.
    task automatic read_miss(input word_t a);
        dif.dREN = 1'b1; dif.daddr = a; dif.ramstate = FREE;
        #1;
        chk("miss_dhit", 32'(dif.dhit), 32'd0);
        chk("miss_dload", dif.dload, 32'd0);
        tick();
        chk("miss_ramren", 32'(dif.ramREN), 32'd1);
        chk("miss_fill_dhit", 32'(dif.dhit), 32'd0);
        dif.dREN = 1'b0;
        tick();
        chk("miss_abandon_ramren", 32'(dif.ramREN), 32'd0);
        quiet();
    endtask

    task automatic write(input word_t a, input word_t d);
        dif.dWEN = 1'b1; dif.daddr = a; dif.dstore = d; dif.ramstate = ACCESS;
        #1;
        chk("wr_idle_dhit", 32'(dif.dhit), 32'd0);
        tick();
        chk("wr_ramwen", 32'(dif.ramWEN), 32'd1);
        chk("wr_ramaddr", dif.ramaddr, a);
        chk("wr_ramstore", dif.ramstore, d);
        chk("wr_dhit", 32'(dif.dhit), 32'd1);
        tick();
        quiet();
    endtask

    initial begin
        quiet();
        dif.daddr = '0; dif.dstore = '0;
        #3;
        chk("rst_dhit", 32'(dif.dhit), 32'd0);
        chk("rst_flushed", 32'(dif.flushed), 32'd0);
        chk("rst_ramren", 32'(dif.ramREN), 32'd0);
        chk("rst_ramwen", 32'(dif.ramWEN), 32'd0);
        chk("rst_hitcount", dif.hitcount, 32'd0);
        #4 nRST = 1'b1;
        tick();

        // Cold read of 0x40: BUSY twice, then ACCESS on the third cycle.
        dif.dREN = 1'b1; dif.daddr = 32'h40; dif.ramstate = BUSY;
        #1;
        chk("s1_c1_dhit", 32'(dif.dhit), 32'd0);
        tick();
        chk("s1_c2_ramren", 32'(dif.ramREN), 32'd1);
        chk("s1_c2_ramaddr", dif.ramaddr, 32'h40);
        chk("s1_c2_dhit", 32'(dif.dhit), 32'd0);
        chk("s1_c2_dload", dif.dload, 32'd0);
        tick();
        chk("s1_c3_busy_hold", 32'(dif.ramREN), 32'd1);
        dif.ramstate = ACCESS; dif.ramload = 32'hDEADBEEF;
        #1;
        chk("s1_c3_dhit", 32'(dif.dhit), 32'd1);
        chk("s1_c3_dload", dif.dload, 32'hDEADBEEF);
        tick();
        quiet();
        chk("s1_idle_ramaddr", dif.ramaddr, 32'd0);
        read_hit(32'h40, 32'hDEADBEEF);

        // Write miss goes through without allocating.
        write(32'h44, 32'h12345678);
        read_miss(32'h44);

        // Write hit updates the resident word.
        write(32'h40, 32'hCAFEF00D);
        read_hit(32'h40, 32'hCAFEF00D);

        // Conflict: 0x60 shares index 0 with 0x40.
        fill(32'h60, 32'h60606060);
        read_hit(32'h60, 32'h60606060);
        read_miss(32'h40);

        // Both requests: write wins; ERROR is retried.
        dif.dREN = 1'b1; dif.dWEN = 1'b1; dif.daddr = 32'h80; dif.dstore = 32'hA5A5A5A5;
        dif.ramstate = ERROR;
        #1;
        tick();
        chk("s5_err_ramwen", 32'(dif.ramWEN), 32'd1);
        chk("s5_err_ramren", 32'(dif.ramREN), 32'd0);
        chk("s5_err_dhit", 32'(dif.dhit), 32'd0);
        tick();
        chk("s5_retry_ramwen", 32'(dif.ramWEN), 32'd1);
        dif.ramstate = ACCESS;
        #1;
        chk("s5_dhit", 32'(dif.dhit), 32'd1);
        chk("s5_ramren", 32'(dif.ramREN), 32'd0);
        chk("s5_ramstore", dif.ramstore, 32'hA5A5A5A5);
        tick();
        quiet();

        // Flush after two fills.
        fill(32'h100, 32'h11111111);
        fill(32'h104, 32'h22222222);
        read_hit(32'h104, 32'h22222222);
        dif.halt = 1'b1;
        tick();
        chk("s6_flushed", 32'(dif.flushed), 32'd1);
        dif.dREN = 1'b1; dif.daddr = 32'h104; dif.ramstate = ACCESS; dif.ramload = 32'h33333333;
        #1;
        chk("s6_dhit", 32'(dif.dhit), 32'd0);
        chk("s6_ramren", 32'(dif.ramREN), 32'd0);
        tick();
        dif.dWEN = 1'b1;
        #1;
        chk("s6_ramwen", 32'(dif.ramWEN), 32'd0);
        chk("s6_still_flushed", 32'(dif.flushed), 32'd1);
        chk("s6_dload", dif.dload, 32'd0);
        quiet();
        nRST = 1'b0;
        #1;
        chk("s6_rst_hitcount", dif.hitcount, 32'd0);
        chk("s6_rst_flushed", 32'(dif.flushed), 32'd0);
        exp_hits = 0;
        #2 nRST = 1'b1;
        tick();
        read_miss(32'h104);
        read_miss(32'h100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dcache_wt.md
DCACHE_WT -- requirements
Module: dcache_wt

Interface
REQ-001 The module SHALL have input CLK, 1 bit: rising-edge clock for all state.
REQ-002 The module SHALL have input nRST, 1 bit: reset, asynchronous, active-low.
REQ-003 The module SHALL have input dREN, 1 bit: datapath read request from the memory stage.
REQ-004 The module SHALL have input dWEN, 1 bit: datapath write request from the memory stage.
REQ-005 The module SHALL have input daddr, 32 bits: byte address; [1:0] ignored.
REQ-006 The module SHALL have input dstore, 32 bits: write data.
REQ-007 The module SHALL have input halt, 1 bit: processor halted, request flush.
REQ-008 The module SHALL have output dhit, 1 bit: request satisfied this cycle; pipeline latches advance on it.
REQ-009 The module SHALL have output dload, 32 bits: read data, valid while dhit and dREN are both high.
REQ-010 The module SHALL have output flushed, 1 bit: cache invalidated after halt.
REQ-011 The module SHALL have output hitcount, 32 bits: read-hit counter.
REQ-012 The module SHALL have outputs ramREN and ramWEN (1 bit each), ramaddr (32 bits) and ramstore (32 bits): memory-side request.
REQ-013 The module SHALL have inputs ramload (32 bits) and ramstate (ramstate_t: FREE, BUSY, ACCESS, ERROR): memory-side response.

Function
REQ-014 The module SHALL implement an 8-entry direct-mapped store: one 32-bit word per entry, indexed by daddr[4:2], tagged by daddr[31:5], with a valid bit per entry.
REQ-015 The FSM SHALL have exactly the states IDLE, FILL, WRITE and FLUSHED.
REQ-016 In IDLE, the module SHALL give dWEN priority over dREN; dWEN=1 SHALL transition to WRITE.
REQ-017 In IDLE, when dREN=1, dWEN=0 and the entry is valid with a matching tag, the module SHALL assert dhit combinationally the same cycle, drive dload from the entry, and increment hitcount (wrapping modulo 2^32); there SHALL be no RAM access.
REQ-018 In IDLE, a dREN read that misses SHALL transition to FILL, with dhit=0.
REQ-019 In IDLE, halt=1 with dREN=dWEN=0 SHALL transition to FLUSHED.
REQ-020 In FILL, the module SHALL drive ramREN=1 and ramaddr={daddr[31:2],2'b00}; on ramstate==ACCESS it SHALL assert dhit, drive dload=ramload, write valid/tag/data into the entry at the clock edge, and return to IDLE.
REQ-021 In WRITE, the module SHALL drive ramWEN=1, ramaddr={daddr[31:2],2'b00} and ramstore=dstore; on ACCESS it SHALL assert dhit and return to IDLE.
REQ-022 A WRITE that matches a valid entry SHALL update that entry's data; on a write miss the module SHALL NOT allocate.
REQ-023 In FILL or WRITE, ramstate BUSY, FREE or ERROR SHALL hold the state, keep dhit=0 and keep the RAM request asserted (ERROR is retried).
REQ-024 If the request drops mid-transaction (dREN=0 in FILL, or dWEN=0 in WRITE), the module SHALL return to IDLE next cycle with no entry update and no dhit.
REQ-025 In FLUSHED, the module SHALL clear all valid bits on entry and assert flushed=1; dhit, ramREN and ramWEN SHALL be held 0; FLUSHED SHALL be exited only by reset.
REQ-026 Outside FILL and WRITE, the module SHALL drive ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-027 dload SHALL be 0 whenever dhit is 0.

Reset
REQ-028 On nRST low, the module SHALL asynchronously set state=IDLE, clear all valid bits, and set hitcount=0; flushed, dhit, ramREN and ramWEN SHALL then read 0. Tag and data contents are don't-care.
REQ-029 Reset mid-FILL or mid-WRITE SHALL abandon the transaction with no entry update.

Structure
REQ-030 ramstate_t and word_t SHALL come from cpu_types_pkg; dcache_entry_t (valid, tag[26:0], data word) and DCACHE_SETS=8 SHALL be added to cpu_types_pkg.
REQ-031 The module SHALL be a single module with no sub-module; the entry array, FSM and counter SHALL be in one file, driven through a dcache_if interface.

Verification
REQ-032 Scenario: read 0x40 cold, ramstate BUSY for 2 cycles then ACCESS with ramload=0xDEADBEEF -> dhit on the 3rd cycle, dload=0xDEADBEEF; re-read 0x40 -> dhit the same cycle, no ramREN, hitcount=1.
REQ-033 Scenario: write 0x44 with dstore=0x12345678 (miss) -> ramWEN, ramaddr=0x44, dhit on ACCESS; read 0x44 -> miss (no allocate).
REQ-034 Scenario: fill 0x40, then write 0x40 with dstore=0xCAFEF00D -> entry updated; read 0x40 hits with dload=0xCAFEF00D.
REQ-035 Scenario: fill 0x40, then read 0x60 (same index, different tag) -> miss and refill; read 0x40 -> miss.
REQ-036 Scenario: dREN and dWEN both high at 0x80 -> WRITE path taken, ramREN=0.
REQ-037 Scenario: halt after two fills -> flushed=1, all valid bits cleared, dhit=0 and no RAM requests while dREN is held high; nRST pulse -> IDLE, hitcount=0.
